// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: FSM encoding, divide
// iteration count and the extended register-file addresses of HI/LO.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  localparam int DIV_ITERS = 32;

  localparam logic [5:0] REG_LO = 6'd32;
  localparam logic [5:0] REG_HI = 6'd33;

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, with sign fix-up and divide-by-zero override on the final result.
module div_core
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        step,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quo_res,
  output logic [31:0] rem_res
);

  logic [31:0] rem_q, quo_q, dvsr_q, dividend_q;
  logic [4:0]  cnt_q;
  logic        neg_quo_q, neg_rem_q, zero_q;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [33:0] diff;
  logic        fits;
  logic [31:0] rem_n, quo_n;

  assign a_neg = is_signed & dividend[31];
  assign b_neg = is_signed & divisor[31];
  assign a_mag = a_neg ? (32'd0 - dividend) : dividend;
  assign b_mag = b_neg ? (32'd0 - divisor) : divisor;

  // Shift the next dividend bit into the partial remainder and try a subtract;
  // the extra top bit of diff is the borrow.
  assign diff  = {1'b0, rem_q, quo_q[31]} - {2'b00, dvsr_q};
  assign fits  = ~diff[33];
  assign rem_n = fits ? diff[31:0] : {rem_q[30:0], quo_q[31]};
  assign quo_n = {quo_q[30:0], fits};

  assign last = (cnt_q == 5'(DIV_ITERS - 1));

  // Results reflect the iteration in flight so the top can register them on
  // the same edge that completes the last iteration.
  assign quo_res = zero_q ? 32'hFFFF_FFFF :
                   (neg_quo_q ? (32'd0 - quo_n) : quo_n);
  assign rem_res = zero_q ? dividend_q :
                   (neg_rem_q ? (32'd0 - rem_n) : rem_n);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      dividend_q <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
    end else if (start) begin
      rem_q      <= '0;
      quo_q      <= a_mag;
      dvsr_q     <= b_mag;
      dividend_q <= dividend;
      cnt_q      <= '0;
      neg_quo_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      zero_q     <= (divisor == 32'd0);
    end else if (step) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: single-cycle multiply, 32-cycle divide, and a
// one-cycle write strobe for the HI/LO registers when a result is ready.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        md_mult_en,
  input  logic        md_div_en,
  input  logic        md_is_signed,
  input  logic [31:0] md_src1,
  input  logic [31:0] md_src2,
  output logic        md_busy,
  output logic        md_we,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  // Handshake: a request (md_mult_en/md_div_en) is taken on any rising edge
  // where md_busy is 0; while md_busy is 1 requests are dropped, not queued.
  md_state_e   state_q, state_d;
  logic        mul_start, div_start;
  logic [31:0] op_a, op_b;
  logic        op_signed;

  logic signed [32:0] ext_a, ext_b;
  logic signed [65:0] prod_full;
  logic [63:0]        product;

  logic        div_last;
  logic [31:0] div_quo, div_rem;

  assign md_busy = (state_q != ST_IDLE);
  assign md_we   = (state_q == ST_DONE);

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (md_mult_en) begin
          state_d   = ST_MUL;
          mul_start = 1'b1;
        end else if (md_div_en) begin
          state_d   = ST_DIV;
          div_start = 1'b1;
        end
      end
      ST_MUL:  state_d = ST_DONE;
      ST_DIV:  if (div_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
    end else if (mul_start) begin
      op_a      <= md_src1;
      op_b      <= md_src2;
      op_signed <= md_is_signed;
    end
  end

  // 33-bit operands let one signed multiplier serve both MULT and MULTU.
  assign ext_a     = $signed({op_signed & op_a[31], op_a});
  assign ext_b     = $signed({op_signed & op_b[31], op_b});
  assign prod_full = ext_a * ext_b;
  assign product   = prod_full[63:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      md_hi <= '0;
      md_lo <= '0;
    end else if (state_q == ST_MUL) begin
      md_hi <= product[63:32];
      md_lo <= product[31:0];
    end else if (state_q == ST_DIV && div_last) begin
      md_hi <= div_rem;
      md_lo <= div_quo;
    end
  end

  div_core u_div_core (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .step      (state_q == ST_DIV),
    .is_signed (md_is_signed),
    .dividend  (md_src1),
    .divisor   (md_src2),
    .last      (div_last),
    .quo_res   (div_quo),
    .rem_res   (div_rem)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: multiply/divide results,
// latency, divide-by-zero, overflow, priority, busy-drop and mid-op reset.
module tb_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        md_mult_en, md_div_en, md_is_signed;
  logic [31:0] md_src1, md_src2;
  logic        md_busy, md_we;
  logic [31:0] md_hi, md_lo;

  int checks   = 0;
  int failures = 0;

  // Observations collected by the driver task
  int          busy_cnt, we_cyc, we_cnt;
  logic [31:0] r_hi, r_lo;

  muldiv_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .md_mult_en   (md_mult_en),
    .md_div_en    (md_div_en),
    .md_is_signed (md_is_signed),
    .md_src1      (md_src1),
    .md_src2      (md_src2),
    .md_busy      (md_busy),
    .md_we        (md_we),
    .md_hi        (md_hi),
    .md_lo        (md_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for one edge, then watch busy cycles at each negedge.
  // A mult request with inj_a/inj_b is held during cycle inj_cyc (0 = none).
  task automatic issue(input bit m, input bit d, input bit s,
                       input logic [31:0] a, input logic [31:0] b,
                       input int inj_cyc, input logic [31:0] inj_a,
                       input logic [31:0] inj_b);
    int cyc;
    @(negedge clk);
    md_mult_en = m; md_div_en = d; md_is_signed = s;
    md_src1 = a; md_src2 = b;
    @(posedge clk);
    #1;
    md_mult_en = 1'b0; md_div_en = 1'b0;
    cyc = 0; busy_cnt = 0; we_cyc = 0; we_cnt = 0; r_hi = 'x; r_lo = 'x;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      md_mult_en = 1'b0;
      if (!md_busy) break;
      cyc++;
      busy_cnt++;
      if (md_we) begin
        we_cyc = cyc; we_cnt++; r_hi = md_hi; r_lo = md_lo;
      end
      if (cyc == inj_cyc) begin
        md_mult_en = 1'b1; md_is_signed = 1'b0;
        md_src1 = inj_a; md_src2 = inj_b;
      end
    end
  endtask

  task automatic check_op(input string name, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    // Inline result comparisons for one completed operation
    checks++;
    if (busy_cnt !== exp_busy || we_cyc !== exp_busy || we_cnt !== 1) begin
      failures++;
      $display("FAIL %s_timing busy=%0d we_cyc=%0d we_cnt=%0d exp busy=we_cyc=%0d we_cnt=1",
               name, busy_cnt, we_cyc, we_cnt, exp_busy);
    end
    checks++;
    if (r_hi !== exp_hi || r_lo !== exp_lo) begin
      failures++;
      $display("FAIL %s_result hi=%h lo=%h exp hi=%h lo=%h",
               name, r_hi, r_lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    md_mult_en = 1'b0; md_div_en = 1'b0; md_is_signed = 1'b0;
    md_src1 = '0; md_src2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (md_busy !== 1'b0 || md_we !== 1'b0 || md_hi !== 32'd0 || md_lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs busy=%b we=%b hi=%h lo=%h exp 0 0 0 0",
               md_busy, md_we, md_hi, md_lo);
    end
    resetn = 1'b1;
  endtask

  task automatic test_mult();
    issue(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    check_op("multu_max", 2, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(1, 0, 1, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
    check_op("mult_neg3x5", 2, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    check_op("mult_m1xm1", 2, 32'h0000_0000, 32'h0000_0001);
    issue(1, 0, 0, 32'h1234_5678, 32'h0000_0010, 0, 0, 0);
    check_op("multu_shift", 2, 32'h0000_0001, 32'h2345_6780);
    // Result must hold after the strobe
    @(negedge clk);
    checks++;
    if (md_hi !== 32'h0000_0001 || md_lo !== 32'h2345_6780 || md_we !== 1'b0) begin
      failures++;
      $display("FAIL result_hold hi=%h lo=%h we=%b exp 00000001 23456780 0",
               md_hi, md_lo, md_we);
    end
  endtask

  task automatic test_div();
    issue(0, 1, 0, 32'd100, 32'd7, 0, 0, 0);
    check_op("divu_100_7", 33, 32'd2, 32'd14);
    issue(0, 1, 1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    check_op("div_m7_2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(0, 1, 1, 32'd7, 32'hFFFF_FFFE, 0, 0, 0);
    check_op("div_7_m2", 33, 32'd1, 32'hFFFF_FFFD);
    issue(0, 1, 0, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    check_op("divu_big_2", 33, 32'd1, 32'h7FFF_FFFC);
    issue(0, 1, 0, 32'hFFFF_FFFF, 32'h10, 0, 0, 0);
    check_op("divu_max_16", 33, 32'hF, 32'h0FFF_FFFF);
    issue(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    check_op("div_overflow", 33, 32'd0, 32'h8000_0000);
  endtask

  task automatic test_div_zero();
    issue(0, 1, 0, 32'd5, 32'd0, 0, 0, 0);
    check_op("divu_5_0", 33, 32'd5, 32'hFFFF_FFFF);
    issue(0, 1, 1, 32'hFFFF_FFF8, 32'd0, 0, 0, 0);
    check_op("div_m8_0", 33, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
  endtask

  task automatic test_priority();
    issue(1, 1, 0, 32'd6, 32'd7, 0, 0, 0);
    check_op("both_req_mult_wins", 2, 32'd0, 32'd42);
  endtask

  task automatic test_busy_ignore();
    issue(0, 1, 0, 32'd100, 32'd7, 10, 32'd9, 32'd9);
    check_op("div_with_mult_in_cyc10", 33, 32'd2, 32'd14);
    // A request in the DONE cycle must not be taken either
    issue(1, 0, 0, 32'd3, 32'd4, 2, 32'd5, 32'd5);
    check_op("mult_req_in_done", 2, 32'd0, 32'd12);
    checks++;
    if (md_busy !== 1'b0) begin
      failures++;
      $display("FAIL done_req_ignored busy=%b exp 0", md_busy);
    end
  endtask

  task automatic test_reset_mid();
    int saw_we;
    saw_we = 0;
    @(negedge clk);
    md_div_en = 1'b1; md_is_signed = 1'b0; md_src1 = 32'd100; md_src2 = 32'd7;
    @(posedge clk);
    #1 md_div_en = 1'b0;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (md_busy !== 1'b0 || md_we !== 1'b0 || md_hi !== 32'd0 || md_lo !== 32'd0) begin
      failures++;
      $display("FAIL midop_reset busy=%b we=%b hi=%h lo=%h exp 0 0 0 0",
               md_busy, md_we, md_hi, md_lo);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (md_we || md_busy) saw_we = 1;
    end
    checks++;
    if (saw_we !== 0) begin
      failures++;
      $display("FAIL abandoned_div_activity seen=%0d exp 0", saw_we);
    end
    issue(1, 0, 0, 32'd2, 32'd3, 0, 0, 0);
    check_op("multu_after_reset", 2, 32'd0, 32'd6);
  endtask

  task automatic test_back_to_back();
    issue(1, 0, 0, 32'd10, 32'd11, 0, 0, 0);
    check_op("b2b_first", 2, 32'd0, 32'd110);
    issue(0, 1, 0, 32'd110, 32'd10, 0, 0, 0);
    check_op("b2b_second", 33, 32'd0, 32'd11);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_priority();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

endmodule
